pll_supervisor: RTL and testbench



---
 rtl/clk_pkg.sv | 24 ++
 rtl/sync2.sv | 21 ++
 rtl/pll_supervisor.sv | 133 +++++++++++++
 tb/tb_pll_supervisor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared clocking/reset definitions: supervisor state encoding and 25 MHz timing defaults.
package clk_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_sup_state_t;

    // Defaults for a 25 MHz reference clock
    localparam int unsigned RST_CYCLES_25M    = 16;
    localparam int unsigned LOCK_TIMEOUT_25M  = 250000;
    localparam int unsigned STABLE_CYCLES_25M = 2500;
    localparam int unsigned CNT_W_DEF         = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; flops clear on reset.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pll_supervisor.sv
// PLL lock supervisor and reset sequencer on the reference clock: pulses the PLL reset,
// qualifies lock, releases the system reset, and counts retries and lock losses.
module pll_supervisor
    import clk_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = RST_CYCLES_25M,
    parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_25M,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_25M,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             locked,
    input  logic             clear_counts,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] retry_count
);

    localparam int unsigned TMR_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RST_END  = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_END = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_END  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    pll_sup_state_t   state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic [CNT_W-1:0] retry_q, retry_d;
    logic             pll_rst_q, sys_rst_q, ready_q;
    logic             lock_s;
    logic             loss_inc, retry_inc;

    sync2 u_lock_sync (
        .clk_i (clkin),
        .rst_i (reset),
        .d_i   (locked),
        .q_o   (lock_s)
    );

    // Next state, shared timer and saturating event counters
    always_comb begin
        state_d   = state_q;
        loss_inc  = 1'b0;
        retry_inc = 1'b0;

        case (state_q)
            RESET_PLL: begin
                if (tmr_q == RST_END) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (tmr_q == LOCK_END) begin
                    state_d   = RESET_PLL;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (tmr_q == STB_END) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d  = RESET_PLL;
                    loss_inc = 1'b1;
                end
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase

        // Timer restarts on every state entry; it idles in RUN where nothing is timed
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (state_q == RUN) begin
            tmr_d = tmr_q;
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        loss_d = loss_q;
        if (loss_inc && (loss_q != CNT_MAX)) begin
            loss_d = loss_q + CNT_W'(1);
        end
        retry_d = retry_q;
        if (retry_inc && (retry_q != CNT_MAX)) begin
            retry_d = retry_q + CNT_W'(1);
        end
        if (clear_counts) begin
            loss_d  = '0;
            retry_d = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_PLL;
            tmr_q     <= '0;
            loss_q    <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            loss_q    <= loss_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == RESET_PLL);
            sys_rst_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign loss_count  = loss_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: directed scenarios plus random lock activity against a
// timestamp-based reference model of the supervisor phases.
module tb_pll_supervisor;

    localparam int RST  = 4;
    localparam int TO   = 20;
    localparam int ST   = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RUN  = 3;

    logic          clkin = 1'b0;
    logic          reset = 1'b0;
    logic          locked = 1'b0;
    logic          clear_counts = 1'b0;
    logic          pll_rst, sys_rst, ready;
    logic [CW-1:0] loss_count, retry_count;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: current phase, edge number at which it was entered, and event counts
    int ph, entry, edge_n, m_loss, m_retry;
    int lk_q[$];

    pll_supervisor #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (ST),
        .CNT_W         (CW)
    ) dut (
        .clkin        (clkin),
        .reset        (reset),
        .locked       (locked),
        .clear_counts (clear_counts),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .loss_count   (loss_count),
        .retry_count  (retry_count)
    );

    always #5 clkin = ~clkin;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        ph      = P_RST;
        entry   = 0;
        edge_n  = 0;
        m_loss  = 0;
        m_retry = 0;
        lk_q    = '{0, 0};
    endtask

    // One clock edge: the synchronized lock seen now is the raw sample from two edges back
    task automatic model_edge(input logic lk, input logic clr);
        int ls, el, nph;
        edge_n++;
        ls = lk_q.pop_front();
        lk_q.push_back(int'(lk));
        el  = edge_n - entry - 1;
        nph = ph;
        case (ph)
            P_RST:  if (el == RST - 1) nph = P_WAIT;
            P_WAIT: begin
                if (ls != 0) nph = P_STB;
                else if (el == TO - 1) begin
                    nph = P_RST;
                    if (m_retry < CMAX) m_retry++;
                end
            end
            P_STB: begin
                if (ls == 0) nph = P_WAIT;
                else if (el == ST - 1) nph = P_RUN;
            end
            default: begin
                if (ls == 0) begin
                    nph = P_RST;
                    if (m_loss < CMAX) m_loss++;
                end
            end
        endcase
        if (nph != ph) entry = edge_n;
        ph = nph;
        if (clr) begin
            m_loss  = 0;
            m_retry = 0;
        end
    endtask

    task automatic check_all();
        chk("pll_rst", 32'(pll_rst), 32'(ph == P_RST));
        chk("sys_rst", 32'(sys_rst), 32'(ph != P_RUN));
        chk("ready", 32'(ready), 32'(ph == P_RUN));
        chk("loss_count", 32'(loss_count), 32'(m_loss));
        chk("retry_count", 32'(retry_count), 32'(m_retry));
    endtask

    task automatic tick();
        @(posedge clkin);
        model_edge(locked, clear_counts);
        #1;
        check_all();
    endtask

    // Asynchronous reset placed between clock edges; outputs must clear before any edge
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("async_pll_rst", 32'(pll_rst), 32'd1);
        chk("async_sys_rst", 32'(sys_rst), 32'd1);
        chk("async_ready", 32'(ready), 32'd0);
        chk("async_loss", 32'(loss_count), 32'd0);
        chk("async_retry", 32'(retry_count), 32'd0);
        @(posedge clkin);
        #3 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int prst_n, rdy_edge, a, entry_s, len, prev;
        int rises[$];

        // 1: lock arrives 10 cycles after reset release
        do_reset();
        prst_n   = 0;
        rdy_edge = -1;
        for (int i = 1; i <= 30; i++) begin
            if (i == 11) locked = 1'b1;
            if (pll_rst) prst_n++;
            tick();
            if (ready && rdy_edge < 0) rdy_edge = edge_n;
        end
        chk("s1_pll_rst_len", 32'(prst_n), 32'(RST));
        chk("s1_ready_edge", 32'(rdy_edge), 32'(11 + 2 + ST));
        chk("s1_sys_rst_low", 32'(sys_rst), 32'd0);

        // 2: no lock at all, retries every RST+TO cycles and saturate
        locked = 1'b0;
        do_reset();
        prev = 1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (pll_rst && prev == 0) rises.push_back(edge_n);
            prev = int'(pll_rst);
        end
        chk("s2_rise_count", 32'(rises.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk("s2_rise_edge", 32'((rises.size() > k) ? rises[k] : -1), 32'((RST + TO) * (k + 1)));
        chk("s2_retry_sat", 32'(retry_count), 32'(CMAX));

        // 3: one-cycle lock glitch while qualifying restarts qualification
        do_reset();
        locked = 1'b1;
        for (int i = 0; i < 40 && ph != P_STB; i++) tick();
        entry_s = entry;
        for (int i = 0; i < 10 && edge_n < entry_s + 3; i++) tick();
        locked = 1'b0;
        tick();
        a = edge_n;
        locked = 1'b1;
        rdy_edge = -1;
        for (int i = 0; i < 40 && !ready; i++) begin
            tick();
            if (ready) rdy_edge = edge_n;
        end
        chk("s3_ready_edge", 32'(rdy_edge), 32'(a + 3 + ST));
        chk("s3_no_count", 32'({loss_count, retry_count}), 32'd0);

        // 4: lock loss in RUN
        locked = 1'b0;
        tick();
        chk("s4_ready_e1", 32'(ready), 32'd1);
        tick();
        chk("s4_ready_e2", 32'(ready), 32'd1);
        tick();
        chk("s4_ready_e3", 32'(ready), 32'd0);
        chk("s4_pll_rst_e3", 32'(pll_rst), 32'd1);
        chk("s4_loss", 32'(loss_count), 32'd1);
        locked = 1'b1;
        for (int i = 0; i < 60 && !ready; i++) tick();
        chk("s4_relock", 32'(ready), 32'd1);

        // 5: clear on the same edge as a loss increment
        locked = 1'b0;
        tick();
        tick();
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        chk("s5_loss_cleared", 32'(loss_count), 32'd0);
        chk("s5_pll_rst", 32'(pll_rst), 32'd1);

        // 6: asynchronous reset in the middle of qualification
        locked = 1'b1;
        for (int i = 0; i < 60 && ph != P_STB; i++) tick();
        tick();
        tick();
        do_reset();
        for (int i = 0; i < 60 && !ready; i++) tick();
        chk("s6_ready_again", 32'(ready), 32'd1);

        // Random lock activity with occasional clears and resets
        for (int seg = 0; seg < 70; seg++) begin
            locked = ($urandom_range(0, 3) != 0);
            len = locked ? int'($urandom_range(1, 25)) : int'($urandom_range(1, 30));
            for (int k = 0; k < len; k++) begin
                clear_counts = ($urandom_range(0, 15) == 0);
                tick();
            end
            clear_counts = 1'b0;
            if ($urandom_range(0, 19) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
